// File: rtl/phy_pkg.sv
// Shared PHY definitions for the two-lane link (TX and RX sides).
//   COMMA_BC : idle/alignment comma symbol
//   SYM_W    : bits per symbol
//   LANES    : number of serial lanes
//   BIT_W    : width of a bit index within a symbol
//   slot_e   : content of the symbol slot currently on the lanes
package phy_pkg;

    localparam int unsigned     SYM_W    = 8;
    localparam int unsigned     LANES    = 2;
    localparam int unsigned     BIT_W    = $clog2(SYM_W);
    localparam logic [SYM_W-1:0] COMMA_BC = 8'hBC;

    typedef enum logic [1:0] {
        SLOT_COMMA,   // idle comma on both lanes
        SLOT_HI,      // upper half of a word (bytes 3/2)
        SLOT_LO       // lower half of a word (bytes 1/0)
    } slot_e;

endpackage

// File: rtl/phy_lane_shifter.sv
// One serial lane: holds the current symbol and shifts it out MSB first.
//   clk       : bit clock
//   rst_n     : asynchronous active-low reset
//   sym_load  : symbol to send in the next slot
//   load      : capture sym_load (asserted on the last bit of a slot)
//   serial    : registered serial bit
//   sym_first : registered, high while serial carries bit 7
//   slot_end  : high while the last bit of the slot is being shifted out
module phy_lane_shifter
    import phy_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] sym_load,
    input  logic             load,
    output logic             serial,
    output logic             sym_first,
    output logic             slot_end
);

    logic [SYM_W-1:0] cur_sym;
    logic [BIT_W-1:0] bit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sym   <= COMMA_BC;
            bit_idx   <= '0;
            serial    <= 1'b0;
            sym_first <= 1'b0;
        end else begin
            serial    <= cur_sym[BIT_W'(SYM_W - 1) - bit_idx];
            sym_first <= (bit_idx == '0);
            // SYM_W is a power of two, so the index wraps naturally
            bit_idx   <= bit_idx + 1'b1;
            if (load) begin
                cur_sym <= sym_load;
            end
        end
    end

    assign slot_end = (bit_idx == BIT_W'(SYM_W - 1));

endmodule

// File: rtl/phy_tx_serializer.sv
// Two-lane PHY transmitter. Accepts 32-bit words on a valid/ready handshake and
// stripes each word over two symbol slots (lane0: bytes 3,1; lane1: bytes 2,0).
// Idle slots carry the 0xBC comma; ready_out stays low until MIN_COMMAS commas
// have been sent after reset.
//   clk_32f       : bit clock
//   reset         : asynchronous active-low reset
//   data_in       : word to transmit
//   valid_in      : data_in valid
//   ready_out     : word accepted on an edge where valid_in && ready_out
//   serial_data_0 : lane 0 serial bit (registered)
//   serial_data_1 : lane 1 serial bit (registered)
//   sym_start     : high while the lanes carry bit 7 of a symbol
module phy_tx_serializer
    import phy_pkg::*;
#(
    parameter int unsigned MIN_COMMAS = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        serial_data_0,
    output logic        serial_data_1,
    output logic        sym_start
);

    localparam int unsigned CW = $clog2(MIN_COMMAS + 1);

    slot_e                        slot_q, slot_d;
    logic [15:0]                  word_q;
    logic [31:0]                  hold_q;
    logic                         hold_full;
    logic [CW-1:0]                comma_cnt;
    logic                         sync_done;
    logic                         take_hold;
    logic                         slot_end;
    logic [LANES-1:0][SYM_W-1:0]  lane_sym;
    logic [LANES-1:0]             lane_ser, lane_first, lane_end;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        phy_lane_shifter u_shift (
            .clk       (clk_32f),
            .rst_n     (reset),
            .sym_load  (lane_sym[i]),
            .load      (slot_end),
            .serial    (lane_ser[i]),
            .sym_first (lane_first[i]),
            .slot_end  (lane_end[i])
        );
    end

    // Lanes share clock and reset, so their bit counters never diverge.
    assign slot_end      = &lane_end;
    assign sym_start     = &lane_first;
    assign serial_data_0 = lane_ser[0];
    assign serial_data_1 = lane_ser[1];

    assign sync_done = (comma_cnt == CW'(MIN_COMMAS));
    assign ready_out = sync_done && !hold_full;

    // Next slot content, chosen on the last bit of the current slot.
    always_comb begin
        slot_d      = slot_q;
        lane_sym[0] = COMMA_BC;
        lane_sym[1] = COMMA_BC;
        take_hold   = 1'b0;
        if (slot_end) begin
            if (slot_q == SLOT_HI) begin
                lane_sym[0] = word_q[15:8];
                lane_sym[1] = word_q[7:0];
                slot_d      = SLOT_LO;
            end else if (hold_full && sync_done) begin
                lane_sym[0] = hold_q[31:24];
                lane_sym[1] = hold_q[23:16];
                take_hold   = 1'b1;
                slot_d      = SLOT_HI;
            end else begin
                slot_d      = SLOT_COMMA;
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            slot_q    <= SLOT_COMMA;
            word_q    <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            comma_cnt <= '0;
        end else begin
            slot_q <= slot_d;
            if (take_hold) begin
                word_q <= hold_q[15:0];
            end
            // An accept on the same edge the hold drains keeps it full.
            if (valid_in && ready_out) begin
                hold_q    <= data_in;
                hold_full <= 1'b1;
            end else if (take_hold) begin
                hold_full <= 1'b0;
            end
            if (slot_end && slot_q == SLOT_COMMA && !sync_done) begin
                comma_cnt <= comma_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phy_tx_serializer.sv
module tb_phy_tx_serializer;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b0;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        serial_data_0;
    logic        serial_data_1;
    logic        sym_start;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;   // clock edges since reset release
    logic [7:0] comma = 8'hBC;

    phy_tx_serializer #(.MIN_COMMAS(4)) dut (
        .clk_32f       (clk_32f),
        .reset         (reset),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .serial_data_0 (serial_data_0),
        .serial_data_1 (serial_data_1),
        .sym_start     (sym_start)
    );

    always #5 clk_32f = ~clk_32f;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_32f);
        @(negedge clk_32f);
        cyc++;
    endtask

    task automatic wait_phase(input int ph);
        for (int k = 0; k < 8 && (cyc % 8) != ph; k++) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        n_vec++; if (serial_data_0 !== 1'b0) begin n_err++; $display("FAIL reset_sd0: got %b expected 0", serial_data_0); end
        n_vec++; if (serial_data_1 !== 1'b0) begin n_err++; $display("FAIL reset_sd1: got %b expected 0", serial_data_1); end
        n_vec++; if (sym_start !== 1'b0) begin n_err++; $display("FAIL reset_sym_start: got %b expected 0", sym_start); end
        n_vec++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", ready_out); end
    endtask

    // Startup: commas on both lanes, ready rises after the 4th comma (edge 32).
    task automatic test_commas();
        logic eb, es, er;
        reset = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            eb = comma[7 - ((k - 1) % 8)];
            es = ((k - 1) % 8) == 0;
            er = (k >= 32);
            n_vec++; if (serial_data_0 !== eb) begin n_err++; $display("FAIL comma_sd0[%0d]: got %b expected %b", k, serial_data_0, eb); end
            n_vec++; if (serial_data_1 !== eb) begin n_err++; $display("FAIL comma_sd1[%0d]: got %b expected %b", k, serial_data_1, eb); end
            n_vec++; if (sym_start !== es) begin n_err++; $display("FAIL comma_sym_start[%0d]: got %b expected %b", k, sym_start, es); end
            n_vec++; if (ready_out !== er) begin n_err++; $display("FAIL comma_ready[%0d]: got %b expected %b", k, ready_out, er); end
        end
    endtask

    // One word accepted on a bit-3 edge; loaded on the next bit-7 edge.
    task automatic test_single_word(input logic [31:0] w, input string tag);
        logic [23:0] e0, e1;
        logic        es;
        e0 = {w[31:24], w[15:8], 8'hBC};
        e1 = {w[23:16], w[7:0], 8'hBC};
        wait_phase(3);
        n_vec++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL %s_ready_pre: got %b expected 1", tag, ready_out); end
        data_in  = w;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        data_in  = 32'h5A5A_A5A5;
        wait_phase(0);
        for (int i = 0; i < 24; i++) begin
            step();
            es = (i % 8) == 0;
            n_vec++; if (serial_data_0 !== e0[23 - i]) begin n_err++; $display("FAIL %s_sd0[%0d]: got %b expected %b", tag, i, serial_data_0, e0[23 - i]); end
            n_vec++; if (serial_data_1 !== e1[23 - i]) begin n_err++; $display("FAIL %s_sd1[%0d]: got %b expected %b", tag, i, serial_data_1, e1[23 - i]); end
            n_vec++; if (sym_start !== es) begin n_err++; $display("FAIL %s_sym_start[%0d]: got %b expected %b", tag, i, sym_start, es); end
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] e0, e1;
        logic        er;
        e0 = 40'h12_56_9A_DE_BC;
        e1 = 40'h34_78_BC_F0_BC;
        wait_phase(3);
        n_vec++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL b2b_ready_pre: got %b expected 1", ready_out); end
        data_in  = 32'h1234_5678;
        valid_in = 1'b1;
        step();                       // first word accepted
        data_in  = 32'h9ABC_DEF0;
        n_vec++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full: got %b expected 0", ready_out); end
        for (int k = 0; k < 8 && (cyc % 8) != 0; k++) begin
            step();
            er = (cyc % 8) == 0;
            n_vec++; if (ready_out !== er) begin n_err++; $display("FAIL b2b_ready_wait[%0d]: got %b expected %b", k, ready_out, er); end
        end
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) begin         // second word accepted on this edge
                valid_in = 1'b0;
                data_in  = 32'hDEAD_BEEF;
            end
            er = (i >= 16);
            n_vec++; if (serial_data_0 !== e0[40 - i]) begin n_err++; $display("FAIL b2b_sd0[%0d]: got %b expected %b", i, serial_data_0, e0[40 - i]); end
            n_vec++; if (serial_data_1 !== e1[40 - i]) begin n_err++; $display("FAIL b2b_sd1[%0d]: got %b expected %b", i, serial_data_1, e1[40 - i]); end
            n_vec++; if (ready_out !== er) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, ready_out, er); end
        end
    endtask

    task automatic test_reset_midword();
        logic eb, er;
        wait_phase(3);
        data_in  = 32'hFFFF_FFFF;
        valid_in = 1'b1;
        step();                       // first word accepted
        wait_phase(0);                // first word loaded
        step();                       // second word accepted into hold
        valid_in = 1'b0;
        for (int k = 0; k < 12; k++) step();   // lanes now carry bit 3 of slot 2
        #1 reset = 1'b0;
        #1;
        n_vec++; if (serial_data_0 !== 1'b0) begin n_err++; $display("FAIL midrst_sd0: got %b expected 0", serial_data_0); end
        n_vec++; if (serial_data_1 !== 1'b0) begin n_err++; $display("FAIL midrst_sd1: got %b expected 0", serial_data_1); end
        n_vec++; if (sym_start !== 1'b0) begin n_err++; $display("FAIL midrst_sym_start: got %b expected 0", sym_start); end
        n_vec++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b expected 0", ready_out); end
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 56; k++) begin
            step();
            eb = comma[7 - ((k - 1) % 8)];
            er = (k >= 32);
            n_vec++; if (serial_data_0 !== eb) begin n_err++; $display("FAIL midrst_comma_sd0[%0d]: got %b expected %b", k, serial_data_0, eb); end
            n_vec++; if (serial_data_1 !== eb) begin n_err++; $display("FAIL midrst_comma_sd1[%0d]: got %b expected %b", k, serial_data_1, eb); end
            n_vec++; if (ready_out !== er) begin n_err++; $display("FAIL midrst_ready[%0d]: got %b expected %b", k, ready_out, er); end
        end
    endtask

    // valid_in pulses before sync must not be captured.
    task automatic test_startup_valid();
        logic eb, er;
        reset = 1'b0;
        @(negedge clk_32f);
        @(negedge clk_32f);
        reset   = 1'b1;
        cyc     = 0;
        data_in = 32'h00FF_00FF;
        for (int k = 1; k <= 56; k++) begin
            valid_in = (k < 30) && ((k % 4) != 0);
            step();
            eb = comma[7 - ((k - 1) % 8)];
            er = (k >= 32);
            n_vec++; if (serial_data_0 !== eb) begin n_err++; $display("FAIL early_valid_sd0[%0d]: got %b expected %b", k, serial_data_0, eb); end
            n_vec++; if (serial_data_1 !== eb) begin n_err++; $display("FAIL early_valid_sd1[%0d]: got %b expected %b", k, serial_data_1, eb); end
            n_vec++; if (ready_out !== er) begin n_err++; $display("FAIL early_valid_ready[%0d]: got %b expected %b", k, ready_out, er); end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commas();
        test_single_word(32'hFFFF_FFFF, "ones");
        test_single_word(32'hF0F0_0F0F, "f0f0");
        test_back_to_back();
        test_reset_midword();
        test_startup_valid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
